// File: rtl/rdata_bus_if.sv
// -----------------------------------------------------------------------------
// rdata_bus_if
// Groups the requester handshake and the shared read-bus signals of the
// round-robin read scheduler into one bundle.
//
//   req        requester -> scheduler   per-requester read request
//   req_addr   requester -> scheduler   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        scheduler -> requester   one-hot acceptance pulse
//   rsp_valid  scheduler -> requester   one-hot response pulse
//   rsp_rdata  scheduler -> requester   returned read data (held between responses)
//   rsp_err    scheduler -> requester   qualifies rsp_valid: access timed out
//   bus_addr   scheduler -> read mux    address to decoder/read mux
//   bus_ren    scheduler -> read mux    read enable
//   bus_ready  read mux  -> scheduler   bus_rdata valid this cycle
//   bus_rdata  read mux  -> scheduler   data from the read mux
//
// Modports:
//   master : the scheduler's view (it masters the shared read bus)
//   slave  : the environment's view (requesters plus the read mux)
// -----------------------------------------------------------------------------
interface rdata_bus_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         bus_addr;
    logic                      bus_ren;
    logic                      bus_ready;
    logic [31:0]               bus_rdata;

    modport master (
        input  req, req_addr, bus_ready, bus_rdata,
        output gnt, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_ren
    );

    modport slave (
        output req, req_addr, bus_ready, bus_rdata,
        input  gnt, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_ren
    );
endinterface

// File: rtl/rdata_bus_scheduler.sv
// -----------------------------------------------------------------------------
// rdata_bus_scheduler
// Round-robin scheduler sharing one register read bus among NUM_REQ
// requesters. One requester is granted at a time; its address is latched and
// driven with bus_ren until the read mux answers with bus_ready, then the
// captured data is returned with a one-cycle one-hot rsp_valid pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rdata_bus_if.master (req/req_addr/gnt/rsp_* to requesters,
//         bus_addr/bus_ren/bus_ready/bus_rdata to the read mux)
//
// Parameters: NUM_REQ (2..8), ADDR_W, TIMEOUT_CYCLES.
//
// Optional feature macro: RDATA_TIMEOUT_EN
//   defined   : an access that sees no bus_ready for TIMEOUT_CYCLES ACCESS
//               cycles is aborted and answered with 32'hBAD0_BAD0, rsp_err=1
//   undefined : ACCESS waits indefinitely, rsp_err is tied low
// -----------------------------------------------------------------------------
module rdata_bus_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    rdata_bus_if.master   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_ren_q, bus_ren_d;

    logic [IDX_W-1:0]    pick_s;
    logic                pick_valid_s;
    logic [IDX_W-1:0]    cand_s;
    logic [ADDR_W-1:0]   addr_arr_s [NUM_REQ];

`ifdef RDATA_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      TO_DATA = 32'hBAD0_BAD0;

    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic                rsp_err_q, rsp_err_d;
`endif

    // Unpack the flat requester address bus into an indexable array.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pick: scan from the farthest candidate back to the nearest
    // so the last hit is the first set bit after last_grant (wrapping).
    always_comb begin
        pick_s       = last_grant_q;
        pick_valid_s = 1'b0;
        cand_s       = last_grant_q;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_s       = IDX_W'((int'(last_grant_q) + off) % NUM_REQ);
            pick_s       = bus.req[cand_s] ? cand_s : pick_s;
            pick_valid_s = bus.req[cand_s] | pick_valid_s;
        end
    end

    // Next-state and registered-output computation for IDLE/ACCESS/RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        bus_addr_d   = bus_addr_q;
        bus_ren_d    = 1'b0;
`ifdef RDATA_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        rsp_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d    = ST_ACCESS;
                    winner_d   = pick_s;
                    gnt_d      = ONE_HOT0 << pick_s;
                    bus_addr_d = addr_arr_s[pick_s];
                    bus_ren_d  = 1'b1;
`ifdef RDATA_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A ready on the final allowed cycle still counts as a normal
                // completion, so it is tested before the timeout.
                if (bus.bus_ready) begin
                    rsp_rdata_d = bus.bus_rdata;
                    rsp_valid_d = ONE_HOT0 << winner_q;
                    state_d     = ST_RESP;
                end
`ifdef RDATA_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    rsp_rdata_d = TO_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = ONE_HOT0 << winner_q;
                    state_d     = ST_RESP;
                end else begin
                    to_cnt_d    = to_cnt_q + CNT_W'(1);
                    bus_ren_d   = 1'b1;
                end
`else
                else begin
                    bus_ren_d   = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                last_grant_d = winner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            winner_q     <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= 32'h0;
            bus_addr_q   <= '0;
            bus_ren_q    <= 1'b0;
`ifdef RDATA_TIMEOUT_EN
            to_cnt_q     <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            bus_addr_q   <= bus_addr_d;
            bus_ren_q    <= bus_ren_d;
`ifdef RDATA_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_ren   = bus_ren_q;
`ifdef RDATA_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rdata_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rdata_bus_scheduler
// Scoreboard bench for rdata_bus_scheduler. The driver issues requests and
// plays the read-mux side; a transaction-level model (round-robin over the
// driven req vector, "free again 3+delay cycles after a grant") predicts each
// grant and response by cycle number and queues it. A negedge monitor pops
// and compares whenever the DUT presents a gnt or rsp_valid, and also checks
// bus_ren/bus_addr windows and rsp_rdata hold behaviour.
// -----------------------------------------------------------------------------
module tb_rdata_bus_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int TO      = 16;

    typedef struct { int cyc; int idx; logic [ADDR_W-1:0] addr; } gnt_exp_t;
    typedef struct { int cyc; int idx; logic [31:0] data; logic err; } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rdata_bus_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bif ();

    rdata_bus_scheduler #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    gnt_exp_t gq[$];
    rsp_exp_t rq[$];
    logic [ADDR_W-1:0] ren_addr [int];

    // model state
    int m_last  = NUM_REQ - 1;
    int m_free  = 0;
    int win_lo  = -1;
    int win_hi  = -2;
    int rdy_cyc = -1;
    logic [31:0] rdy_data = 32'h0;
    logic [NUM_REQ*ADDR_W-1:0] addrs = '0;

    bit mon_en = 1'b0;
    bit rst_prev = 1'b0;
    logic [31:0] hold = 32'h0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus and let the model predict its consequences.
    task automatic step(input logic [NUM_REQ-1:0] reqv, input int dly,
                        input logic [31:0] data, input bit r, output int won);
        int p, w, ed;
        bit err;
        int ks[$];
        @(posedge clk);
        #1;
        p   = cyc;
        won = -1;
        rst = r;
        bif.req      = reqv;
        bif.req_addr = addrs;
        if (p >= win_lo && p <= win_hi) begin
            bif.bus_ready = (p == rdy_cyc);
            bif.bus_rdata = (p == rdy_cyc) ? rdy_data : $urandom;
        end else begin
            bif.bus_ready = 1'($urandom_range(0, 1));
            bif.bus_rdata = $urandom;
        end
        if (r) begin
            while (gq.size() > 0 && gq[$].cyc > p) void'(gq.pop_back());
            while (rq.size() > 0 && rq[$].cyc > p) void'(rq.pop_back());
            foreach (ren_addr[k]) if (k > p) ks.push_back(k);
            foreach (ks[j]) ren_addr.delete(ks[j]);
            win_hi  = p;
            rdy_cyc = -1;
            m_free  = p + 1;
            m_last  = NUM_REQ - 1;
        end else if (p >= m_free && reqv != '0) begin
            w   = rr_pick(m_last, reqv);
            ed  = dly;
            err = 1'b0;
`ifdef RDATA_TIMEOUT_EN
            if (dly >= TO) begin
                ed  = TO - 1;
                err = 1'b1;
            end
`endif
            gq.push_back('{p + 1, w, addrs[w*ADDR_W +: ADDR_W]});
            rq.push_back('{p + 2 + ed, w, err ? 32'hBAD0_BAD0 : data, err});
            for (int c = p + 1; c <= p + 1 + ed; c++) ren_addr[c] = addrs[w*ADDR_W +: ADDR_W];
            win_lo   = p + 1;
            win_hi   = p + 1 + ed;
            rdy_cyc  = err ? -1 : p + 1 + dly;
            rdy_data = data;
            m_free   = p + 3 + ed;
            m_last   = w;
            won      = w;
        end
    endtask

    task automatic idle(input int n);
        int w;
        repeat (n) step('0, 0, 32'h0, 1'b0, w);
    endtask

    // Monitor: compares DUT outputs against queued expectations at each negedge.
    initial begin
        gnt_exp_t ge;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_prev) hold = 32'h0;
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    ge = gq.pop_front();
                    chk("gnt_vec", 64'(bif.gnt), 64'(1 << ge.idx));
                    chk("gnt_addr", 64'(bif.bus_addr), 64'(ge.addr));
                end else if (bif.gnt != '0) begin
                    chk("gnt_spurious", 64'(bif.gnt), 64'h0);
                end
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    re = rq.pop_front();
                    chk("rsp_valid", 64'(bif.rsp_valid), 64'(1 << re.idx));
                    chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(re.data));
                    chk("rsp_err", 64'(bif.rsp_err), 64'(re.err));
                    hold = re.data;
                end else begin
                    if (bif.rsp_valid != '0) chk("rsp_spurious", 64'(bif.rsp_valid), 64'h0);
                    chk("rsp_rdata_hold", 64'(bif.rsp_rdata), 64'(hold));
                end
                chk("bus_ren", 64'(bif.bus_ren), 64'(ren_addr.exists(cyc) ? 1 : 0));
                if (ren_addr.exists(cyc)) begin
                    chk("bus_addr", 64'(bif.bus_addr), 64'(ren_addr[cyc]));
                    ren_addr.delete(cyc);
                end
                if ((bif.gnt & bif.rsp_valid) != '0) chk("gnt_rsp_overlap", 64'(bif.gnt & bif.rsp_valid), 64'h0);
            end
            rst_prev = rst;
        end
    end

    // Stimulus: directed scenarios, then randomized traffic, then drain.
    initial begin
        int w;
        int dly;
        logic [NUM_REQ-1:0] pend;
        pend          = '0;
        bif.req       = '0;
        bif.req_addr  = '0;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'h0;

        step('0, 0, 32'h0, 1'b1, w);
        step('0, 0, 32'h0, 1'b1, w);
        mon_en = 1'b1;
        chk("rst_gnt", 64'(bif.gnt), 64'h0);
        chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'h0);
        chk("rst_rsp_err", 64'(bif.rsp_err), 64'h0);
        chk("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'h0);
        chk("rst_bus_addr", 64'(bif.bus_addr), 64'h0);
        chk("rst_bus_ren", 64'(bif.bus_ren), 64'h0);

        // single request, immediate ready
        addrs[0 +: ADDR_W] = 32'h8000_0010;
        step(4'b0001, 0, 32'h1234_5678, 1'b0, w);
        idle(4);

        // reset during ACCESS drops the pending response; then requester 1
        step(4'b0001, 30, $urandom, 1'b0, w);
        idle(2);
        step('0, 0, 32'h0, 1'b1, w);
        idle(3);
        addrs[1*ADDR_W +: ADDR_W] = 32'h4000_0104;
        step(4'b0010, 0, $urandom, 1'b0, w);
        idle(4);

        // last_grant=1, req=1001: 3 before 0
        addrs[3*ADDR_W +: ADDR_W] = 32'h0000_0C0C;
        repeat (4) step(4'b1001, 0, $urandom, 1'b0, w);
        idle(4);

        // after reset, all four held: 0,1,2,3,0 three cycles apart
        step('0, 0, 32'h0, 1'b1, w);
        addrs[2*ADDR_W +: ADDR_W] = 32'h2222_0008;
        repeat (13) step(4'b1111, 0, $urandom, 1'b0, w);
        idle(4);

        // bus_ready delayed 5 cycles; addr changes after grant are ignored
        step(4'b0100, 5, 32'hCAFE_F00D, 1'b0, w);
        addrs[2*ADDR_W +: ADDR_W] = 32'hDEAD_0000;
        idle(10);

        // no ready for 20 cycles (timeout when enabled), then ready on 16th cycle
        step(4'b0001, 20, 32'h5555_AAAA, 1'b0, w);
        idle(25);
        step(4'b0001, 15, 32'h0BAD_CAFE, 1'b0, w);
        idle(20);

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
                    addrs[i*ADDR_W +: ADDR_W] = $urandom;
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: dly = $urandom_range(0, 2);
                6, 7:             dly = $urandom_range(3, 6);
                8:                dly = 15;
                default:          dly = $urandom_range(16, 20);
            endcase
            step(pend, dly, $urandom, ($urandom_range(0, 399) == 0), w);
            if (w >= 0) pend[w] = 1'b0;
        end

        // drain outstanding expectations within a bounded number of cycles
        for (int k = 0; k < 60 && (gq.size() > 0 || rq.size() > 0); k++) idle(1);
        idle(2);
        @(negedge clk);
        chk("drain_gnt_queue", 64'(gq.size()), 64'h0);
        chk("drain_rsp_queue", 64'(rq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
